// File: rtl/labyrinth_pkg.sv
// Shared labyrinth definitions: direction bit indices, ball FSM states, grid and colour defaults.
// Latency: none, this file holds only constants, types and a combinational helper.
// Backpressure: not applicable.
package labyrinth_pkg;

  // Bit positions inside the {right, left, down, up} request and wall vectors
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  // Default maze dimensions in cells
  localparam int DEF_MAP_W = 128;
  localparam int DEF_MAP_H = 128;

  // Colour painted on the ball cell
  localparam logic [7:0] DEF_BALL_PIXEL = 8'hE0;

  // READY accepts a move on a tick; SETTLE gives the map ROM one cycle to re-read
  typedef enum logic {
    READY  = 1'b0,
    SETTLE = 1'b1
  } ball_state_t;

  // Reduce a request vector to a single winner: up > down > left > right.
  // A lower-priority bit is dropped whenever a higher one is set, even if the
  // higher one later turns out to be blocked.
  function automatic logic [3:0] pick_winner(input logic [3:0] req);
    logic [3:0] win;
    win = 4'b0000;
    if (req[DIR_UP])         win[DIR_UP]    = 1'b1;
    else if (req[DIR_DOWN])  win[DIR_DOWN]  = 1'b1;
    else if (req[DIR_LEFT])  win[DIR_LEFT]  = 1'b1;
    else if (req[DIR_RIGHT]) win[DIR_RIGHT] = 1'b1;
    return win;
  endfunction

endpackage

// File: rtl/labyrinth_ball_move_tick_gen.sv
// Move-rate divider: free-running 0..MOVE_DIV-1 counter, tick while the count sits at MOVE_DIV-1.
// Latency: tick is combinational from the count; first tick is seen by the MOVE_DIV-th edge after reset.
// Backpressure: none, the counter never stalls.
module move_tick_gen #(
  parameter int MOVE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count up and wrap after the last value so ticks are exactly MOVE_DIV cycles apart
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/labyrinth_ball.sv
// Player-ball controller: one-cell moves per tick, edge clamp, wall block (BALL_COLLISION_EN), ball pixel.
// Latency: position updates on the tick edge; vid_pixel_out is registered one cycle after vid_row/vid_col.
// Backpressure: none; requests are level-sensitive and simply ignored while illegal or while settling.
module labyrinth_ball
  import labyrinth_pkg::*;
#(
  parameter int                COORD_W    = 7,
  parameter int                MAP_W      = DEF_MAP_W,
  parameter int                MAP_H      = DEF_MAP_H,
  parameter int                START_X    = 0,
  parameter int                START_Y    = 0,
  parameter int                MOVE_DIV   = 4,
  parameter int                PIX_W      = 8,
  parameter logic [PIX_W-1:0]  BALL_PIXEL = PIX_W'(DEF_BALL_PIXEL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         map_value,
  input  logic [3:0]         movement,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  input  logic [COORD_W-1:0] vid_row,
  input  logic [COORD_W-1:0] vid_col,
  output logic [PIX_W-1:0]   vid_pixel_out
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(MAP_H - 1);
  localparam logic [COORD_W-1:0] X_RESET = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_RESET = COORD_W'(START_Y);

  logic               tick;
  ball_state_t        state;
  ball_state_t        state_nxt;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic [3:0]         winner;
  logic [3:0]         wall;
  logic [3:0]         at_edge;
  logic               move_ok;

  move_tick_gen #(
    .MOVE_DIV (MOVE_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef BALL_COLLISION_EN
  // Wall flags of the current cell block the matching direction
  assign wall = map_value;
`else
  // No-clip build: walls are ignored, only the grid edge holds the ball
  logic unused_map_value;
  assign wall             = 4'b0000;
  assign unused_map_value = ^map_value;
`endif

  // Mark directions that would leave the grid; checked before any add/subtract
  always_comb begin
    at_edge            = 4'b0000;
    at_edge[DIR_UP]    = (y_out == '0);
    at_edge[DIR_DOWN]  = (y_out == Y_MAX);
    at_edge[DIR_LEFT]  = (x_out == '0);
    at_edge[DIR_RIGHT] = (x_out == X_MAX);
  end

  // Only the highest-priority request is considered; a blocked winner means no move
  assign winner  = pick_winner(movement);
  assign move_ok = (winner != 4'b0000) && ((winner & (wall | at_edge)) == 4'b0000);

  // Next-state and next-position: move only from READY on a tick, then settle one cycle
  always_comb begin
    state_nxt = state;
    x_nxt     = x_out;
    y_nxt     = y_out;
    case (state)
      READY: begin
        if (tick && move_ok) begin
          state_nxt = SETTLE;
          if (winner[DIR_UP]) begin
            y_nxt = y_out - COORD_W'(1);
          end else if (winner[DIR_DOWN]) begin
            y_nxt = y_out + COORD_W'(1);
          end else if (winner[DIR_LEFT]) begin
            x_nxt = x_out - COORD_W'(1);
          end else begin
            x_nxt = x_out + COORD_W'(1);
          end
        end
      end
      SETTLE: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = READY;
      end
    endcase
  end

  // State and position registers; reset overrides any move landing on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= READY;
      x_out <= X_RESET;
      y_out <= Y_RESET;
    end else begin
      state <= state_nxt;
      x_out <= x_nxt;
      y_out <= y_nxt;
    end
  end

  // Paint the ball cell, comparing the scan position against the position held at this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_pixel_out <= '0;
    end else if ((vid_row == y_out) && (vid_col == x_out)) begin
      vid_pixel_out <= BALL_PIXEL;
    end else begin
      vid_pixel_out <= '0;
    end
  end

endmodule

// File: tb/tb_labyrinth_ball.sv
module tb_labyrinth_ball;

`ifdef BALL_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  localparam int SEL_X    = 0;
  localparam int SEL_Y    = 1;
  localparam int SEL_PIX  = 2;
  localparam int SEL_X2   = 3;
  localparam int SEL_Y2   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] map_value;
  logic [3:0] movement;
  logic [3:0] movement2;
  logic [3:0] map_zero;
  logic [6:0] vid_row;
  logic [6:0] vid_col;
  logic [6:0] vid_zero;
  logic [6:0] x_out, y_out, x2, y2;
  logic [7:0] pix, pix2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  labyrinth_ball #(
    .MOVE_DIV (4),
    .START_X  (5),
    .START_Y  (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .map_value     (map_value),
    .movement      (movement),
    .x_out         (x_out),
    .y_out         (y_out),
    .vid_row       (vid_row),
    .vid_col       (vid_col),
    .vid_pixel_out (pix)
  );

  labyrinth_ball #(
    .MOVE_DIV (4),
    .START_X  (127),
    .START_Y  (0)
  ) dut_edge (
    .clk           (clk),
    .reset         (reset),
    .map_value     (map_zero),
    .movement      (movement2),
    .x_out         (x2),
    .y_out         (y2),
    .vid_row       (vid_zero),
    .vid_col       (vid_zero),
    .vid_pixel_out (pix2)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic push(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] obs;
      e = sb.pop_front();
      case (e.sel)
        SEL_X:   obs = {1'b0, x_out};
        SEL_Y:   obs = {1'b0, y_out};
        SEL_PIX: obs = pix;
        SEL_X2:  obs = {1'b0, x2};
        default: obs = {1'b0, y2};
      endcase
      checks++;
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    map_value = 4'b0000;
    map_zero  = 4'b0000;
    movement  = 4'b0000;
    movement2 = 4'b0000;
    vid_row   = 7'd0;
    vid_col   = 7'd0;
    vid_zero  = 7'd0;

    // Reset state
    push("rst_x", SEL_X, 8'd5);
    push("rst_y", SEL_Y, 8'd5);
    push("rst_pix", SEL_PIX, 8'h00);
    push("rst_x2", SEL_X2, 8'd127);
    push("rst_y2", SEL_Y2, 8'd0);
    cyc(10);
    drain();

    // Free moves: first move on the 4th edge, next one 4 cycles later
    reset    = 1'b0;
    movement = 4'b0001;
    push("up_pre_tick_y", SEL_Y, 8'd5);
    cyc(3);
    drain();
    push("up_tick1_y", SEL_Y, 8'd4);
    push("up_tick1_x", SEL_X, 8'd5);
    cyc(1);
    drain();
    push("up_mid_y", SEL_Y, 8'd4);
    cyc(3);
    drain();
    push("up_tick2_y", SEL_Y, 8'd3);
    push("up_tick2_x", SEL_X, 8'd5);
    cyc(1);
    drain();

    // Wall above blocks up; same wall does not block down
    do_reset();
    map_value = 4'b0001;
    movement  = 4'b0001;
    push("wall_up_y", SEL_Y, COLL ? 8'd5 : 8'd4);
    cyc(4);
    drain();
    movement = 4'b0010;
    push("wall_down_y", SEL_Y, COLL ? 8'd6 : 8'd5);
    cyc(4);
    drain();

    // Priority: up beats right; a blocked up does not fall through to right
    do_reset();
    map_value = 4'b0000;
    movement  = 4'b1001;
    push("prio_y", SEL_Y, 8'd4);
    push("prio_x", SEL_X, 8'd5);
    cyc(4);
    drain();
    map_value = 4'b0001;
    push("prio_blk_y", SEL_Y, COLL ? 8'd4 : 8'd3);
    push("prio_blk_x", SEL_X, 8'd5);
    cyc(4);
    drain();
    map_value = 4'b0000;
    movement  = 4'b0000;

    // Edges: top row with up, right column with right, then leave the edge
    do_reset();
    movement2 = 4'b0001;
    push("edge_up_y2", SEL_Y2, 8'd0);
    push("edge_up_x2", SEL_X2, 8'd127);
    cyc(8);
    drain();
    movement2 = 4'b1000;
    push("edge_right_x2", SEL_X2, 8'd127);
    push("edge_right_y2", SEL_Y2, 8'd0);
    cyc(8);
    drain();
    movement2 = 4'b0100;
    push("edge_left_x2", SEL_X2, 8'd125);
    cyc(8);
    drain();
    movement2 = 4'b0000;

    // Video compare with one-cycle latency, and no request holds position
    movement = 4'b0000;
    do_reset();
    vid_row = 7'd5;
    vid_col = 7'd5;
    push("vid_hit", SEL_PIX, 8'hE0);
    cyc(1);
    drain();
    vid_col = 7'd6;
    push("vid_miss", SEL_PIX, 8'h00);
    cyc(1);
    drain();
    vid_col = 7'd5;
    push("idle_x", SEL_X, 8'd5);
    push("idle_y", SEL_Y, 8'd5);
    push("idle_pix", SEL_PIX, 8'hE0);
    cyc(8);
    drain();

    // Pixel uses the position held at the sampling edge, then reset mid-stream
    movement = 4'b0001;
    do_reset();
    push("vid_old_pos_pix", SEL_PIX, 8'hE0);
    push("vid_old_pos_y", SEL_Y, 8'd4);
    cyc(4);
    drain();
    push("vid_moved_pix", SEL_PIX, 8'h00);
    cyc(1);
    drain();
    cyc(2);
    reset = 1'b1;
    push("midrst_y", SEL_Y, 8'd5);
    push("midrst_x", SEL_X, 8'd5);
    push("midrst_pix", SEL_PIX, 8'h00);
    cyc(1);
    drain();
    reset    = 1'b0;
    movement = 4'b0000;
    push("post_rst_pix", SEL_PIX, 8'hE0);
    push("post_rst_y", SEL_Y, 8'd5);
    cyc(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
